sar_seq_ctrl: RTL and testbench

Parametrised successive-approximation controller for the mixed-signal ADC front end. It drives the sample-and-hold enable, the analog input mux select and the R-2R DAC trial code. It resolves one bit per clock from the comparator output and delivers results with their channel tag over a valid/ready interface. It generalises the fixed 8-bit single-channel controller in the following ways:
- configurable resolution
- multi-channel scan
- continuous mode
- output backpressure
- optional oversampling average

---
 rtl/sar_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: successive-approximation ADC sequencer.
// Drives the sample-and-hold enable, the analog mux select and the DAC trial code.
// Resolves one bit per clock and hands results out over valid/ready.
// Optional feature macro: SAR_AVG_EN adds a 2^AVG_LOG2-conversion oversampling average.
module sar_seq_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SAMPLE_CYCLES = 2,
`ifdef SAR_AVG_EN
  parameter int unsigned AVG_LOG2      = 2,
`endif
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             scan,
  input  logic             continuous,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             comp_in,
  output logic             sh_en,
  output logic [CH_W-1:0]  mux_sel,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             valid,
  input  logic             ready
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic               r_scan;
  logic [SMP_W-1:0]   r_smp_cnt;
  logic [BIT_W-1:0]   r_bit;
  logic               r_sh_en;
  logic [CH_W-1:0]    r_mux_sel;
  logic [WIDTH-1:0]   r_dac_code;
  logic               r_busy;
  logic [WIDTH-1:0]   r_result;
  logic [CH_W-1:0]    r_result_ch;
  logic               r_valid;

  logic [WIDTH-1:0]   w_trial;
  logic [CH_W-1:0]    w_ch_wrap;
  logic               w_out_free;
  logic               w_last_bit;
  logic               w_last_conv;
  logic               w_load;
  logic               w_scan_more;
  logic [WIDTH-1:0]   w_done_code;
  logic [WIDTH-1:0]   w_hold_code;
  logic [WIDTH-1:0]   w_load_code;

  assign sh_en     = r_sh_en;
  assign mux_sel   = r_mux_sel;
  assign dac_code  = r_dac_code;
  assign busy      = r_busy;
  assign result    = r_result;
  assign result_ch = r_result_ch;
  assign valid     = r_valid;

  // Out-of-range channel requests fold back onto the populated mux inputs.
  assign w_ch_wrap   = CH_W'(32'(ch_sel) % CHANNELS);
  assign w_scan_more = r_scan && (32'(r_mux_sel) < (CHANNELS - 1));
  // The output register can take a new result if empty or being drained this cycle.
  assign w_out_free  = !r_valid || ready;
  assign w_last_bit  = (r_bit == '0);
  assign w_load      = w_out_free &&
                       (((r_state == S_CONVERT) && w_last_bit && w_last_conv) ||
                        (r_state == S_HOLD));
  assign w_load_code = (r_state == S_HOLD) ? w_hold_code : w_done_code;

  // Next trial: resolve the bit under test from the comparator, then arm the next lower bit.
  always_comb begin
    w_trial        = r_dac_code;
    w_trial[r_bit] = comp_in;
    if (!w_last_bit) begin
      w_trial[r_bit - BIT_W'(1)] = 1'b1;
    end
  end

`ifdef SAR_AVG_EN
  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_avg_cnt;
  logic [ACC_W-1:0] w_acc_sum;

  assign w_acc_sum   = r_acc + ACC_W'(w_trial);
  assign w_last_conv = (r_avg_cnt == CNT_W'((1 << AVG_LOG2) - 1));
  assign w_done_code = WIDTH'(w_acc_sum >> AVG_LOG2);
  assign w_hold_code = WIDTH'(r_acc >> AVG_LOG2);

  // Sum the final codes of one channel's conversions; cleared whenever a result is delivered.
  always_ff @(posedge clk) begin
    if (reset_in || w_load || (r_state == S_IDLE)) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if ((r_state == S_CONVERT) && w_last_bit) begin
      r_acc     <= w_acc_sum;
      r_avg_cnt <= r_avg_cnt + CNT_W'(1);
    end
  end
`else
  assign w_last_conv = 1'b1;
  assign w_done_code = w_trial;
  assign w_hold_code = r_dac_code;
`endif

  // Sequencer FSM with registered outputs; a result load overrides the per-state updates.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state     <= S_IDLE;
      r_scan      <= 1'b0;
      r_smp_cnt   <= '0;
      r_bit       <= '0;
      r_sh_en     <= 1'b0;
      r_mux_sel   <= '0;
      r_dac_code  <= '0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_result_ch <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_sh_en    <= 1'b0;
          r_dac_code <= '0;
          r_busy     <= 1'b0;
          if (start) begin
            r_scan    <= scan;
            r_mux_sel <= scan ? '0 : w_ch_wrap;
            r_smp_cnt <= '0;
            r_sh_en   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (r_smp_cnt == SMP_W'(SAMPLE_CYCLES - 1)) begin
            r_sh_en    <= 1'b0;
            r_dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
            r_bit      <= BIT_W'(WIDTH - 1);
            r_state    <= S_CONVERT;
          end else begin
            r_smp_cnt <= r_smp_cnt + SMP_W'(1);
          end
        end

        S_CONVERT: begin
          r_dac_code <= w_trial;
          r_bit      <= r_bit - BIT_W'(1);
          if (w_last_bit) begin
            if (!w_last_conv) begin
              // Another conversion of the same channel for the running average.
              r_dac_code <= '0;
              r_smp_cnt  <= '0;
              r_sh_en    <= 1'b1;
              r_state    <= S_SAMPLE;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          r_state <= S_HOLD;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_load) begin
        r_result    <= w_load_code;
        r_result_ch <= r_mux_sel;
        r_valid     <= 1'b1;
        r_dac_code  <= '0;
        r_smp_cnt   <= '0;
        if (w_scan_more) begin
          r_mux_sel <= r_mux_sel + CH_W'(1);
          r_sh_en   <= 1'b1;
          r_state   <= S_SAMPLE;
        end else if (continuous) begin
          r_scan    <= scan;
          r_mux_sel <= scan ? '0 : w_ch_wrap;
          r_sh_en   <= 1'b1;
          r_state   <= S_SAMPLE;
        end else begin
          r_sh_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Testbench for sar_seq_ctrl: ideal comparator on per-channel input voltages,
// results checked against an ideal-quantiser reference and a binary-search trial model.
module tb_sar_seq_ctrl;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SC = 2;
`ifdef SAR_AVG_EN
  localparam int AVG_N = 2;
`else
  localparam int AVG_N = 1;
`endif
  localparam int T_RES  = AVG_N * (SC + W);
  localparam int BP_WIN = (3 * T_RES > 30) ? 3 * T_RES : 30;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         start;
  logic         scan;
  logic         continuous;
  logic [1:0]   ch_sel;
  logic         comp_in;
  logic         sh_en;
  logic [1:0]   mux_sel;
  logic [W-1:0] dac_code;
  logic         busy;
  logic [W-1:0] result;
  logic [1:0]   result_ch;
  logic         valid;
  logic         ready;

  logic [W-1:0] vin [CH];

  int n_checks = 0;
  int n_fail   = 0;

  sar_seq_ctrl #(
    .WIDTH(W),
    .CHANNELS(CH),
    .SAMPLE_CYCLES(SC)
`ifdef SAR_AVG_EN
    , .AVG_LOG2(1)
`endif
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .start(start),
    .scan(scan),
    .continuous(continuous),
    .ch_sel(ch_sel),
    .comp_in(comp_in),
    .sh_en(sh_en),
    .mux_sel(mux_sel),
    .dac_code(dac_code),
    .busy(busy),
    .result(result),
    .result_ch(result_ch),
    .valid(valid),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Ideal comparator on the currently selected input.
  assign comp_in = (vin[mux_sel] >= dac_code);

  // Binary-search reference: trial code presented at step i for input v.
  function automatic logic [W-1:0] trial_at(input logic [W-1:0] v, input int i);
    logic [W-1:0] code;
    logic [W-1:0] t;
    code = '0;
    for (int k = 0; k < i; k++) begin
      t = code | (8'h80 >> k);
      if (v >= t) code = t;
    end
    return code | (8'h80 >> i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sh_en"},     32'(sh_en),     32'd0);
    check({tag, "_mux_sel"},   32'(mux_sel),   32'd0);
    check({tag, "_dac_code"},  32'(dac_code),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_result_ch"}, 32'(result_ch), 32'd0);
    check({tag, "_valid"},     32'(valid),     32'd0);
  endtask

  // One single-channel conversion with ready held high.
  task automatic run_single(input int ch, input logic [W-1:0] v, input bit chk_trials);
    int           cyc;
    logic [W-1:0] seen [W];
    for (int i = 0; i < W; i++) seen[i] = '0;
    vin[ch] = v; ch_sel = 2'(ch); scan = 1'b0; continuous = 1'b0; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_sh_en", 32'(sh_en), 32'd1);
    check("launch_mux", 32'(mux_sel), 32'(ch));
    while (valid !== 1'b1 && cyc < 4 * T_RES) begin
      if (cyc >= SC && cyc < SC + W) seen[cyc - SC] = dac_code;
      tick();
      cyc++;
    end
    check("single_latency", 32'(cyc), 32'(T_RES));
    check("single_result", 32'(result), 32'(v));
    check("single_result_ch", 32'(result_ch), 32'(ch));
    check("single_busy_fall", 32'(busy), 32'd0);
    if (chk_trials) begin
      for (int i = 0; i < W; i++) check($sformatf("trial%0d", i), 32'(seen[i]), 32'(trial_at(v, i)));
    end
    tick();
    check("single_valid_clear", 32'(valid), 32'd0);
  endtask

  // One full channel sweep with ready held high, using the current vin[] contents.
  task automatic run_scan();
    int cyc;
    int last;
    scan = 1'b1; continuous = 1'b0; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    last = 0;
    check("scan_mux0", 32'(mux_sel), 32'd0);
    for (int k = 0; k < CH; k++) begin
      while (valid !== 1'b1 && cyc < last + 4 * T_RES) begin
        tick();
        cyc++;
      end
      check($sformatf("scan_spacing%0d", k), 32'(cyc - last), 32'(T_RES));
      check($sformatf("scan_result%0d", k), 32'(result), 32'(vin[k]));
      check($sformatf("scan_ch%0d", k), 32'(result_ch), 32'(k));
      last = cyc;
      tick();
      cyc++;
    end
    check("scan_busy_low", 32'(busy), 32'd0);
    check("scan_valid_low", 32'(valid), 32'd0);
  endtask

`ifdef SAR_AVG_EN
  // Two conversions of channel 0 with a different input for each.
  task automatic run_avg_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int           cyc;
    logic [W:0]   sum;
    vin[0] = a; ch_sel = 2'd0; scan = 1'b0; continuous = 1'b0; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 4 * T_RES) begin
      tick();
      cyc++;
      if (cyc == SC + W) vin[0] = b;
    end
    sum = {1'b0, a} + {1'b0, b};
    check("avg_latency", 32'(cyc), 32'(2 * (SC + W)));
    check("avg_result", 32'(result), 32'(sum[W:1]));
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    int           e;
    int           guard;
    bit           stable_ok;
    logic [W-1:0] v;

    reset_in = 1'b1; start = 1'b0; scan = 1'b0; continuous = 1'b0;
    ch_sel = 2'd0; ready = 1'b1;
    for (int k = 0; k < CH; k++) vin[k] = '0;
    tick();
    tick();
    reset_in = 1'b0;
    check_all_zero("reset");

    // Directed single conversion with trial sequence.
    run_single(2, 8'hA5, 1'b1);

    // Extremes.
    run_single(1, 8'h00, 1'b1);
    run_single(3, 8'hFF, 1'b1);

    // Randomized singles.
    for (int i = 0; i < 4; i++) begin
      run_single(int'($urandom_range(0, CH - 1)), 8'($urandom_range(0, 255)), 1'b1);
    end

    // Scan sweeps: directed then randomized inputs.
    vin[0] = 8'h10; vin[1] = 8'h20; vin[2] = 8'h30; vin[3] = 8'h40;
    run_scan();
    for (int k = 0; k < CH; k++) vin[k] = 8'($urandom_range(0, 255));
    run_scan();

    // Backpressure in continuous scan mode.
    for (int k = 0; k < CH; k++) vin[k] = 8'($urandom_range(0, 255));
    scan = 1'b1; continuous = 1'b1; ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 4 * T_RES) begin
      tick();
      cyc++;
    end
    check("bp_first_latency", 32'(cyc), 32'(T_RES));
    check("bp_first_result", 32'(result), 32'(vin[0]));
    stable_ok = 1'b1;
    while (cyc < BP_WIN) begin
      tick();
      cyc++;
      if (valid !== 1'b1 || result !== vin[0] || result_ch !== 2'd0) stable_ok = 1'b0;
      if (cyc == 2 * T_RES + 1) check("bp_hold_dac_early", 32'(dac_code), 32'(vin[1]));
    end
    check("bp_held_stable", 32'(stable_ok), 32'd1);
    check("bp_hold_dac_late", 32'(dac_code), 32'(vin[1]));
    check("bp_hold_sh_en", 32'(sh_en), 32'd0);
    check("bp_hold_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    e = 0;
    guard = 0;
    while (!(busy === 1'b0 && valid === 1'b0) && guard < 20 * T_RES) begin
      if (valid === 1'b1) begin
        check($sformatf("bp_res%0d", e), 32'(result), 32'(vin[e % CH]));
        check($sformatf("bp_ch%0d", e), 32'(result_ch), 32'(e % CH));
        e++;
        if (e == 6) continuous = 1'b0;
      end
      tick();
      guard++;
    end
    check("bp_total_results", 32'(e), 32'd8);

    // Reset during CONVERT step 3.
    v = 8'($urandom_range(0, 255));
    vin[0] = v; ch_sel = 2'd0; scan = 1'b0; continuous = 1'b0; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SC + 3) tick();
    check("rst_step3_dac", 32'(dac_code), 32'(trial_at(v, 3)));
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check_all_zero("midreset");
    tick();
    check("midreset_stays_idle", 32'(busy), 32'd0);
    run_single(0, 8'($urandom_range(0, 255)), 1'b1);

`ifdef SAR_AVG_EN
    run_avg_pair(8'h80, 8'h81);
    run_avg_pair(8'hFF, 8'hFE);
    run_avg_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
